// File: rtl/rgb2gray_pkg.sv
// rgb2gray_pkg: shared constants and types for the RGB888 -> gray converter.
//   - default channel/address widths and the frame size
//   - mode encodings and the per-mode channel weights
//   - FSM state encoding for the fetch controller
package rgb2gray_pkg;

   localparam int unsigned CH_WIDTH   = 8;
   localparam int unsigned ADDR_WIDTH = 16;
   localparam int unsigned N_PIX      = 65536;

   localparam logic [1:0] MODE_BT601 = 2'd0;
   localparam logic [1:0] MODE_BT709 = 2'd1;
   localparam logic [1:0] MODE_AVG   = 2'd2;
   localparam logic [1:0] MODE_GREEN = 2'd3;

   // Each weight set sums to 256. A weight of 256 does not fit in 8 bits, so the
   // green-only mode is flagged with g_shift and handled as a left shift by 8.
   typedef struct packed {
      logic [7:0] w_r;
      logic [7:0] w_g;
      logic [7:0] w_b;
      logic       g_shift;
   } weights_t;

   localparam weights_t W_BT601 = '{w_r: 8'd77, w_g: 8'd150, w_b: 8'd29, g_shift: 1'b0};
   localparam weights_t W_BT709 = '{w_r: 8'd54, w_g: 8'd183, w_b: 8'd19, g_shift: 1'b0};
   localparam weights_t W_AVG   = '{w_r: 8'd85, w_g: 8'd86,  w_b: 8'd85, g_shift: 1'b0};
   localparam weights_t W_GREEN = '{w_r: 8'd0,  w_g: 8'd0,   w_b: 8'd0,  g_shift: 1'b1};

   typedef enum logic [1:0] {
      StIdle,
      StFetch,
      StDrain,
      StDone
   } state_e;

   function automatic weights_t mode_weights(input logic [1:0] mode);
      weights_t w;
      case (mode)
         MODE_BT601: w = W_BT601;
         MODE_BT709: w = W_BT709;
         MODE_AVG:   w = W_AVG;
         default:    w = W_GREEN;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/rgb2gray_if.sv
// rgb2gray_if: fetch port towards the RGB source memory and write port towards
// the gray memory.
//   rgb_addr/rgb_req   : fetch request (converter -> source)
//   rgb_ready/rgb_data : source availability and {R,G,B} data (source -> converter)
//   gray_addr/valid/data : one-cycle write strobe into the gray memory
// Modports: master = converter side, slave = memories/environment side.
interface rgb2gray_if #(
   parameter int unsigned Ch_Width   = 8,
   parameter int unsigned Addr_Width = 16
);
   logic [Addr_Width-1:0] rgb_addr;
   logic                  rgb_req;
   logic                  rgb_ready;
   logic [3*Ch_Width-1:0] rgb_data;
   logic [Addr_Width-1:0] gray_addr;
   logic                  gray_valid;
   logic [Ch_Width-1:0]   gray_data;

   modport master (
      output rgb_addr, rgb_req, gray_addr, gray_valid, gray_data,
      input  rgb_ready, rgb_data
   );

   modport slave (
      input  rgb_addr, rgb_req, gray_addr, gray_valid, gray_data,
      output rgb_ready, rgb_data
   );
endinterface

// File: rtl/rgb2gray_gray_mac.sv
// gray_mac: two-stage weighted-sum datapath.
//   S1 registers the three channel products and the pixel address.
//   S2 adds the products plus a rounding constant and keeps bits [15:8].
// Ports:
//   clk, rst (async, active low)
//   in_valid_i, rgb_i {R,G,B}, addr_i, mode_i : accepted pixel and latched mode
//   s1_valid_o  : stage-1 valid bit (used by the controller to detect drain)
//   out_valid_o, gray_o, addr_o : registered write strobe, gray value, address
module gray_mac
   import rgb2gray_pkg::*;
#(
   parameter int unsigned Ch_Width   = CH_WIDTH,
   parameter int unsigned Addr_Width = ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid_i,
   input  logic [3*Ch_Width-1:0] rgb_i,
   input  logic [Addr_Width-1:0] addr_i,
   input  logic [1:0]            mode_i,
   output logic                  s1_valid_o,
   output logic                  out_valid_o,
   output logic [Ch_Width-1:0]   gray_o,
   output logic [Addr_Width-1:0] addr_o
);

   localparam int unsigned PW = Ch_Width + 8;

   weights_t              w;
   logic [Ch_Width-1:0]   ch_r, ch_g, ch_b;
   logic [PW-1:0]         prod_r_d, prod_g_d, prod_b_d;
   logic [PW-1:0]         prod_r_q, prod_g_q, prod_b_q;
   logic [Addr_Width-1:0] addr1_q, addr2_q;
   logic                  v1_q, v2_q;
   logic [PW:0]           sum;
   logic [Ch_Width-1:0]   gray_d, gray_q;

   always_comb begin
      w        = mode_weights(mode_i);
      ch_r     = rgb_i[3*Ch_Width-1 -: Ch_Width];
      ch_g     = rgb_i[2*Ch_Width-1 -: Ch_Width];
      ch_b     = rgb_i[Ch_Width-1 -: Ch_Width];
      prod_r_d = PW'(ch_r) * PW'(w.w_r);
      prod_b_d = PW'(ch_b) * PW'(w.w_b);
      prod_g_d = w.g_shift ? {ch_g, 8'h00} : PW'(ch_g) * PW'(w.w_g);
   end

   // Max sum is 255*256+128, so the shifted result always fits: no clamp.
   always_comb begin
      sum    = {1'b0, prod_r_q} + {1'b0, prod_g_q} + {1'b0, prod_b_q} + (PW+1)'(128);
      gray_d = Ch_Width'(sum >> 8);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prod_r_q <= '0;
         prod_g_q <= '0;
         prod_b_q <= '0;
         addr1_q  <= '0;
         v1_q     <= 1'b0;
         gray_q   <= '0;
         addr2_q  <= '0;
         v2_q     <= 1'b0;
      end else begin
         v1_q <= in_valid_i;
         if (in_valid_i) begin
            prod_r_q <= prod_r_d;
            prod_g_q <= prod_g_d;
            prod_b_q <= prod_b_d;
            addr1_q  <= addr_i;
         end
         v2_q <= v1_q;
         if (v1_q) begin
            gray_q  <= gray_d;
            addr2_q <= addr1_q;
         end
      end
   end

   assign s1_valid_o  = v1_q;
   assign out_valid_o = v2_q;
   assign gray_o      = gray_q;
   assign addr_o      = addr2_q;

endmodule

// File: rtl/rgb2gray.sv
// rgb2gray: streams an RGB888 frame from the source memory, converts each pixel
// to gray with mode-selected weights and writes it to the gray memory.
// Ports:
//   clk, rst (async, active low)
//   mode   : weight select, latched when a frame starts
//   bus    : rgb2gray_if.master (fetch port + gray write port)
//   finish : frame done, held until reset
//   gray_min/gray_max : running min/max of written gray values, present only
//                       when GRAY_STATS_EN is defined
module rgb2gray
   import rgb2gray_pkg::*;
#(
   parameter int unsigned Ch_Width   = CH_WIDTH,
   parameter int unsigned Addr_Width = ADDR_WIDTH,
   parameter int unsigned N_Pix      = N_PIX
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] mode,
   rgb2gray_if.master bus,
   output logic       finish
`ifdef GRAY_STATS_EN
   ,
   output logic [Ch_Width-1:0] gray_min,
   output logic [Ch_Width-1:0] gray_max
`endif
);

   localparam logic [Addr_Width-1:0] LastAddr = Addr_Width'(N_Pix - 1);

   state_e                state_q;
   logic                  req_q;
   logic [Addr_Width-1:0] addr_q;
   logic [1:0]            mode_q;
   logic                  finish_q;
   logic                  accept;
   logic                  s1_valid, s2_valid;
   logic [Ch_Width-1:0]   gray;
   logic [Addr_Width-1:0] gray_addr;

   assign accept = req_q & bus.rgb_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         req_q    <= 1'b0;
         addr_q   <= '0;
         mode_q   <= MODE_BT601;
         finish_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.rgb_ready) begin
                  state_q <= StFetch;
                  req_q   <= 1'b1;
                  addr_q  <= '0;
                  mode_q  <= mode;
               end
            end
            StFetch: begin
               if (accept) begin
                  // Stop on the last address instead of wrapping to 0.
                  if (addr_q == LastAddr) begin
                     state_q <= StDrain;
                     req_q   <= 1'b0;
                  end else begin
                     addr_q <= addr_q + 1'b1;
                  end
               end
            end
            StDrain: begin
               // With S1 empty nothing can enter S2, so both valid bits are 0 after
               // this edge; finish then rises right after the final write cycle.
               if (!s1_valid) begin
                  state_q  <= StDone;
                  finish_q <= 1'b1;
               end
            end
            StDone: ;
            default: state_q <= StIdle;
         endcase
      end
   end

   gray_mac #(
      .Ch_Width  (Ch_Width),
      .Addr_Width(Addr_Width)
   ) u_mac (
      .clk        (clk),
      .rst        (rst),
      .in_valid_i (accept),
      .rgb_i      (bus.rgb_data),
      .addr_i     (addr_q),
      .mode_i     (mode_q),
      .s1_valid_o (s1_valid),
      .out_valid_o(s2_valid),
      .gray_o     (gray),
      .addr_o     (gray_addr)
   );

   assign bus.rgb_req    = req_q;
   assign bus.rgb_addr   = addr_q;
   assign bus.gray_valid = s2_valid;
   assign bus.gray_data  = gray;
   assign bus.gray_addr  = gray_addr;
   assign finish         = finish_q;

`ifdef GRAY_STATS_EN
   logic [Ch_Width-1:0] min_q, max_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         min_q <= '1;
         max_q <= '0;
      end else if (s2_valid) begin
         if (gray < min_q) min_q <= gray;
         if (gray > max_q) max_q <= gray;
      end
   end

   assign gray_min = min_q;
   assign gray_max = max_q;
`else
   // Statistics disabled: no extra ports or state.
`endif

endmodule

// File: tb/tb_rgb2gray.sv
// tb_rgb2gray: self-checking bench for rgb2gray on a reduced 256-pixel frame.
// A behavioural model computes each gray value with integer arithmetic from the
// weight table; a monitor records accepts and writes with their cycle numbers.
module tb_rgb2gray;

   localparam int NPix = 256;

   logic       clk  = 1'b0;
   logic       rst  = 1'b1;
   logic [1:0] mode = 2'd0;
   logic       finish;
`ifdef GRAY_STATS_EN
   logic [7:0] gray_min, gray_max;
`endif

   rgb2gray_if bus ();

   rgb2gray #(.N_Pix(NPix)) dut (
      .clk   (clk),
      .rst   (rst),
      .mode  (mode),
      .bus   (bus),
      .finish(finish)
`ifdef GRAY_STATS_EN
      ,
      .gray_min(gray_min),
      .gray_max(gray_max)
`endif
   );

   always #5 clk = ~clk;

   // Source memory: data for the requested address is available combinationally.
   logic [23:0] src_mem [NPix];
   assign bus.rgb_data = src_mem[bus.rgb_addr[7:0]];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input longint got, input longint exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   int wtab [4][3] = '{'{77, 150, 29}, '{54, 183, 19}, '{85, 86, 85}, '{0, 256, 0}};

   function automatic int model_gray(input int m, input logic [23:0] p);
      int s;
      s = int'(p[23:16]) * wtab[m][0] + int'(p[15:8]) * wtab[m][1] +
          int'(p[7:0]) * wtab[m][2] + 128;
      return s / 256;
   endfunction

   // Monitor.
   int cyc = 0;
   int acc_addr[$], acc_cyc[$], wr_addr[$], wr_data[$], wr_cyc[$];
   int fin_cyc = 0;
   bit fin_seen = 1'b0;
   int overlap = 0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rst) begin
         if (bus.rgb_req && bus.rgb_ready) begin
            acc_addr.push_back(int'(bus.rgb_addr));
            acc_cyc.push_back(cyc);
         end
         if (bus.gray_valid) begin
            wr_addr.push_back(int'(bus.gray_addr));
            wr_data.push_back(int'(bus.gray_data));
            wr_cyc.push_back(cyc);
         end
         if (finish && !fin_seen) begin
            fin_seen = 1'b1;
            fin_cyc  = cyc;
         end
         if (finish && bus.gray_valid) overlap++;
      end
   end

   task automatic reset_dut(input int m);
      bus.rgb_ready = 1'b0;
      mode = 2'(m);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_rgb_req", bus.rgb_req, 0);
      check("rst_rgb_addr", bus.rgb_addr, 0);
      check("rst_gray_valid", bus.gray_valid, 0);
      check("rst_gray_addr", bus.gray_addr, 0);
      check("rst_gray_data", bus.gray_data, 0);
      check("rst_finish", finish, 0);
`ifdef GRAY_STATS_EN
      check("rst_gray_min", gray_min, 255);
      check("rst_gray_max", gray_max, 0);
`endif
      acc_addr.delete(); acc_cyc.delete();
      wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
      fin_seen = 1'b0;
      overlap  = 0;
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("idle_rgb_req", bus.rgb_req, 0);
      check("idle_finish", finish, 0);
   endtask

   // One full frame in mode m; rnd toggles rgb_ready at 50%; if chg_at >= 0 the
   // mode input changes after that many accepts (must have no effect).
   task automatic run_frame(input int m, input bit rnd, input int chg_at);
      bit done;
      int lo, hi, e;
      reset_dut(m);
      done = 1'b0;
      for (int k = 0; k < 8 * NPix + 50 && !done; k++) begin
         @(posedge clk);
         #1;
         bus.rgb_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (chg_at >= 0 && acc_addr.size() >= chg_at) mode = 2'(m + 1);
         if (finish) done = 1'b1;
      end
      check("frame_done", done, 1);
      bus.rgb_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("finish_held", finish, 1);
      check("req_after_done", bus.rgb_req, 0);
      check("accept_count", acc_addr.size(), NPix);
      check("write_count", wr_addr.size(), NPix);
      for (int i = 0; i < acc_addr.size() && i < NPix; i++)
         check("accept_addr", acc_addr[i], i);
      lo = 255;
      hi = 0;
      for (int i = 0; i < NPix; i++) begin
         e = model_gray(m, src_mem[i]);
         if (e < lo) lo = e;
         if (e > hi) hi = e;
      end
      for (int i = 0; i < wr_addr.size() && i < NPix; i++) begin
         check("write_addr", wr_addr[i], i);
         check("gray_data", wr_data[i], model_gray(m, src_mem[i]));
         if (i < acc_cyc.size()) check("latency", wr_cyc[i] - acc_cyc[i], 2);
      end
      check("finish_seen", fin_seen, 1);
      if (fin_seen && wr_cyc.size() > 0)
         check("finish_gap", fin_cyc - wr_cyc[wr_cyc.size() - 1], 1);
      check("finish_with_valid", overlap, 0);
`ifdef GRAY_STATS_EN
      check("gray_min", gray_min, lo);
      check("gray_max", gray_max, hi);
`endif
   endtask

   typedef struct {
      int          m;
      logic [23:0] rgb;
      int          exp;
   } vec_t;

   vec_t vecs [12];
   int   slot [12];

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      bit ok;
      int k;
      vecs[0]  = '{0, {8'd255, 8'd0,   8'd0  }, 77};
      vecs[1]  = '{0, {8'd255, 8'd255, 8'd255}, 255};
      vecs[2]  = '{0, {8'd0,   8'd255, 8'd0  }, 149};
      vecs[3]  = '{0, {8'd0,   8'd0,   8'd255}, 29};
      vecs[4]  = '{1, {8'd255, 8'd0,   8'd0  }, 54};
      vecs[5]  = '{1, {8'd0,   8'd255, 8'd0  }, 182};
      vecs[6]  = '{1, {8'd0,   8'd0,   8'd0  }, 0};
      vecs[7]  = '{2, {8'd10,  8'd20,  8'd30 }, 20};
      vecs[8]  = '{2, {8'd255, 8'd255, 8'd255}, 255};
      vecs[9]  = '{3, {8'd200, 8'd77,  8'd9  }, 77};
      vecs[10] = '{3, {8'd0,   8'd255, 8'd0  }, 255};
      vecs[11] = '{1, {8'd100, 8'd100, 8'd100}, 100};

      bus.rgb_ready = 1'b0;

      // One frame per mode: table vectors first, random pixels after.
      for (int m = 0; m < 4; m++) begin
         for (int i = 0; i < NPix; i++) src_mem[i] = 24'($urandom);
         k = 0;
         for (int v = 0; v < 12; v++) begin
            if (vecs[v].m == m) begin
               src_mem[k] = vecs[v].rgb;
               slot[v] = k;
               k++;
            end
         end
         run_frame(m, m[0], -1);
         for (int v = 0; v < 12; v++) begin
            if (vecs[v].m == m && slot[v] < wr_data.size())
               check("vector", wr_data[slot[v]], vecs[v].exp);
         end
      end

      // Random pixels with a stalling source.
      for (int i = 0; i < NPix; i++) src_mem[i] = 24'($urandom);
      run_frame(0, 1'b1, -1);

      // Asynchronous reset in the middle of a fetch, then a clean frame with a
      // mode change part-way through.
      reset_dut(1);
      ok = 1'b0;
      for (int c = 0; c < 4 * NPix; c++) begin
         @(posedge clk);
         #1 bus.rgb_ready = 1'b1;
         if (bus.rgb_addr == 16'd100) begin
            ok = 1'b1;
            break;
         end
      end
      check("reach_addr_100", ok, 1);
      #3 rst = 1'b0;
      #1;
      check("async_rgb_req", bus.rgb_req, 0);
      check("async_rgb_addr", bus.rgb_addr, 0);
      check("async_gray_valid", bus.gray_valid, 0);
      check("async_gray_addr", bus.gray_addr, 0);
      check("async_gray_data", bus.gray_data, 0);
      check("async_finish", finish, 0);
      run_frame(2, 1'b1, 50);

      // Flat frame with one black and one full-green pixel, green-only mode.
      for (int i = 0; i < NPix; i++) src_mem[i] = {8'd128, 8'd128, 8'd128};
      src_mem[10] = 24'h000000;
      src_mem[20] = {8'd0, 8'd255, 8'd0};
      run_frame(3, 1'b0, -1);
`ifdef GRAY_STATS_EN
      check("stats_min_flat", gray_min, 0);
      check("stats_max_flat", gray_max, 255);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
